// File: rtl/exception_sequencer_if.sv
// +----------------------------------------------------------------------------+
// | exception_sequencer_if                                                     |
// | Control-unit / memory / register-file side bus of the exception sequencer. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

interface exception_sequencer_if #(
    parameter int N_CAUSES = 4,
    parameter int ADDR_W   = 32
);
    logic                exc_valid;
    logic [N_CAUSES-1:0] exc_cause;
    logic [ADDR_W-1:0]   pc_in;
    logic [7:0]          mem_rdata;
    logic                rte;
    logic                mem_rd;
    logic [ADDR_W-1:0]   mem_addr;
    logic                epc_we;
    logic [ADDR_W-1:0]   epc_out;
    logic                pc_we;
    logic [ADDR_W-1:0]   pc_out;
    logic                busy;
    logic                done;
    logic                exc_lost;
    logic [N_CAUSES-1:0] cause_o;

    modport master (
        output exc_valid, exc_cause, pc_in, mem_rdata, rte,
        input  mem_rd, mem_addr, epc_we, epc_out, pc_we, pc_out,
               busy, done, exc_lost, cause_o
    );

    modport slave (
        input  exc_valid, exc_cause, pc_in, mem_rdata, rte,
        output mem_rd, mem_addr, epc_we, epc_out, pc_we, pc_out,
               busy, done, exc_lost, cause_o
    );
endinterface

`default_nettype wire

// File: rtl/exception_sequencer.sv
// +----------------------------------------------------------------------------+
// | exception_sequencer                                                        |
// | Prioritised multi-cycle exception entry: save EPC, fetch the handler byte  |
// | from the vector table, load PC. Optional cause register: EXC_CAUSE_REG_EN. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module exception_sequencer #(
    parameter int N_CAUSES  = 4,
    parameter int ADDR_W    = 32,
    parameter int VEC_BASE  = 253,
    parameter int PC_OFFSET = 4,
    parameter int MEM_LAT   = 1
) (
    input  wire logic               clk,
    input  wire logic               reset,
    exception_sequencer_if.slave    bus
);
    localparam int c_IDX_W = (N_CAUSES > 1) ? $clog2(N_CAUSES) : 1;
    localparam int c_CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SAVE = 3'd1,
        S_RD   = 3'd2,
        S_WAIT = 3'd3,
        S_LOAD = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_IDX_W-1:0]   w_idx;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]    r_epc;
    logic [ADDR_W-1:0]    r_addr;
    logic [ADDR_W-1:0]    r_pc_out;
    logic                 r_lost;
    logic                 w_take;
    logic                 w_last_wait;

    assign w_take      = bus.exc_valid && (bus.exc_cause != '0);
    assign w_last_wait = (r_state == S_WAIT) && (r_cnt == '0);

    // Lowest set bit wins: scan from the top so the last hit is the lowest index.
    always_comb begin
        w_idx = '0;
        for (int i = N_CAUSES - 1; i >= 0; i--) begin
            if (bus.exc_cause[i]) begin
                w_idx = c_IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        bus.epc_we = 1'b0;
        bus.mem_rd = 1'b0;
        bus.pc_we  = 1'b0;
        bus.done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_take) begin
                    w_next = S_SAVE;
                end
            end
            S_SAVE: begin
                bus.epc_we = 1'b1;
                w_next     = S_RD;
            end
            S_RD: begin
                bus.mem_rd = 1'b1;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                bus.pc_we = 1'b1;
                bus.done  = 1'b1;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_epc    <= '0;
            r_addr   <= '0;
            r_pc_out <= '0;
            r_lost   <= 1'b0;
        end else begin
            r_state <= w_next;
            // EPC is formed at accept so epc_out is already valid in the SAVE cycle.
            if (r_state == S_IDLE && w_take) begin
                r_idx <= w_idx;
                r_epc <= bus.pc_in - ADDR_W'(PC_OFFSET);
            end
            if (r_state == S_SAVE) begin
                r_addr <= ADDR_W'(VEC_BASE) + ADDR_W'(r_idx);
            end
            if (r_state == S_RD) begin
                r_cnt <= c_CNT_W'(MEM_LAT - 1);
            end else if (r_state == S_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end
            if (w_last_wait) begin
                r_pc_out <= ADDR_W'(bus.mem_rdata);
            end
            if (r_state != S_IDLE && w_take) begin
                r_lost <= 1'b1;
            end
        end
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.epc_out  = r_epc;
    assign bus.mem_addr = r_addr;
    assign bus.pc_out   = r_pc_out;
    assign bus.exc_lost = r_lost;

`ifdef EXC_CAUSE_REG_EN
    logic [N_CAUSES-1:0] r_cause;

    // SAVE has priority over rte; rte is only honoured while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cause <= '0;
        end else if (r_state == S_SAVE) begin
            r_cause <= N_CAUSES'(1) << r_idx;
        end else if (r_state == S_IDLE && bus.rte) begin
            r_cause <= '0;
        end
    end

    assign bus.cause_o = r_cause;
`else
    logic w_unused_rte;

    assign w_unused_rte = bus.rte;
    assign bus.cause_o  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_exception_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_exception_sequencer                                                     |
// | Scoreboard bench: lane 0 uses MEM_LAT=1, lane 1 uses MEM_LAT=3.            |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_exception_sequencer;
    typedef struct {
        int          lane;
        int          cyc;
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic rst1;
    logic rst3;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    bit   mon_en = 1'b0;

    exp_t q_epc[$];
    exp_t q_addr[$];
    exp_t q_pc[$];

    int          busy_lo[2];
    int          busy_hi[2];
    bit          exp_lost[2];
    logic [3:0]  exp_cause[2];
    int          rd_cyc[2];
    logic [7:0]  rd_byte[2];

    exception_sequencer_if #(.N_CAUSES(4), .ADDR_W(32)) bus1 ();
    exception_sequencer_if #(.N_CAUSES(4), .ADDR_W(32)) bus3 ();

    exception_sequencer #(
        .N_CAUSES(4), .ADDR_W(32), .VEC_BASE(253), .PC_OFFSET(4), .MEM_LAT(1)
    ) dut1 (
        .clk(clk), .reset(rst1), .bus(bus1)
    );

    exception_sequencer #(
        .N_CAUSES(4), .ADDR_W(32), .VEC_BASE(253), .PC_OFFSET(4), .MEM_LAT(3)
    ) dut3 (
        .clk(clk), .reset(rst3), .bus(bus3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input int lane, input int c, input logic [31:0] v);
        exp_t e;
        e.lane = lane;
        e.cyc  = c;
        e.val  = v;
        return e;
    endfunction

    function automatic logic [3:0] cause_exp(input logic [3:0] v);
`ifdef EXC_CAUSE_REG_EN
        return v;
`else
        return 4'b0000 & v;
`endif
    endfunction

    task automatic chk(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s lane%0d cycle %0d: got %h, expected %h", name, lane, cyc, act, exp);
    endtask

    task automatic bad(input string name, input int lane);
        checks++;
        $display("FAIL %s lane%0d cycle %0d: got pulse state inconsistent with expected schedule", name, lane, cyc);
    endtask

    task automatic observe(input int lane, input logic ew, input logic [31:0] eo,
                           input logic mr, input logic [31:0] ma,
                           input logic pw, input logic [31:0] po, input logic dn,
                           input logic bs, input logic lost, input logic [3:0] co);
        if (ew) begin
            if (q_epc.size() > 0 && q_epc[0].lane == lane && q_epc[0].cyc == cyc) begin
                chk("epc_out", lane, eo, q_epc[0].val);
                void'(q_epc.pop_front());
            end else bad("epc_we_unexpected", lane);
        end
        if (mr) begin
            if (q_addr.size() > 0 && q_addr[0].lane == lane && q_addr[0].cyc == cyc) begin
                chk("mem_addr", lane, ma, q_addr[0].val);
                void'(q_addr.pop_front());
            end else bad("mem_rd_unexpected", lane);
        end
        if (pw) begin
            if (q_pc.size() > 0 && q_pc[0].lane == lane && q_pc[0].cyc == cyc) begin
                chk("pc_out", lane, po, q_pc[0].val);
                chk("done", lane, {31'b0, dn}, 32'd1);
                void'(q_pc.pop_front());
            end else bad("pc_we_unexpected", lane);
        end else if (dn) begin
            bad("done_without_pc_we", lane);
        end
        chk("busy", lane, {31'b0, bs}, {31'b0, (cyc >= busy_lo[lane] && cyc <= busy_hi[lane])});
        chk("exc_lost", lane, {31'b0, lost}, {31'b0, exp_lost[lane]});
        chk("cause_o", lane, {28'b0, co}, {28'b0, exp_cause[lane]});
    endtask

    task automatic expire();
        while (q_epc.size() > 0 && q_epc[0].cyc < cyc) begin
            bad("epc_we_missing", q_epc[0].lane);
            void'(q_epc.pop_front());
        end
        while (q_addr.size() > 0 && q_addr[0].cyc < cyc) begin
            bad("mem_rd_missing", q_addr[0].lane);
            void'(q_addr.pop_front());
        end
        while (q_pc.size() > 0 && q_pc[0].cyc < cyc) begin
            bad("pc_we_missing", q_pc[0].lane);
            void'(q_pc.pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            observe(0, bus1.epc_we, bus1.epc_out, bus1.mem_rd, bus1.mem_addr, bus1.pc_we,
                    bus1.pc_out, bus1.done, bus1.busy, bus1.exc_lost, bus1.cause_o);
            observe(1, bus3.epc_we, bus3.epc_out, bus3.mem_rd, bus3.mem_addr, bus3.pc_we,
                    bus3.pc_out, bus3.done, bus3.busy, bus3.exc_lost, bus3.cause_o);
            expire();
        end
    end

    // Memory model: the handler byte only in the one cycle it must be captured.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            bus1.mem_rdata = (cyc == rd_cyc[0]) ? rd_byte[0] : ~rd_byte[0];
            bus3.mem_rdata = (cyc == rd_cyc[1]) ? rd_byte[1] : ~rd_byte[1];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int lane, input logic v, input logic [3:0] c, input logic [31:0] p);
        if (lane == 0) begin
            bus1.exc_valid = v; bus1.exc_cause = c; bus1.pc_in = p;
        end else begin
            bus3.exc_valid = v; bus3.exc_cause = c; bus3.pc_in = p;
        end
    endtask

    task automatic set_rte(input int lane, input logic v);
        if (lane == 0) bus1.rte = v;
        else           bus3.rte = v;
    endtask

    task automatic set_rst(input int lane, input logic v);
        if (lane == 0) rst1 = v;
        else           rst3 = v;
    endtask

    task automatic check_zero(input int lane);
        if (lane == 0) begin
            chk("rst_epc_out", lane, bus1.epc_out, 32'h0);
            chk("rst_mem_addr", lane, bus1.mem_addr, 32'h0);
            chk("rst_pc_out", lane, bus1.pc_out, 32'h0);
            chk("rst_pulses", lane, {28'b0, bus1.epc_we, bus1.mem_rd, bus1.pc_we, bus1.done}, 32'h0);
        end else begin
            chk("rst_epc_out", lane, bus3.epc_out, 32'h0);
            chk("rst_mem_addr", lane, bus3.mem_addr, 32'h0);
            chk("rst_pc_out", lane, bus3.pc_out, 32'h0);
            chk("rst_pulses", lane, {28'b0, bus3.epc_we, bus3.mem_rd, bus3.pc_we, bus3.done}, 32'h0);
        end
    endtask

    // One full exception entry starting in the current cycle (cycle 0).
    task automatic seq(input int lane, input logic [3:0] cause, input logic [31:0] pc,
                       input logic [7:0] b, input int lat, input bit drop_save,
                       input bit drop_load, input bit rst_wait, input bit rte_busy);
        int c0;
        int idx;
        bit found;
        c0 = cyc;
        idx = 0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (cause[i] && !found) begin
                idx = i;
                found = 1'b1;
            end
        end
        set_req(lane, 1'b1, cause, pc);
        q_epc.push_back(mk(lane, c0 + 1, pc - 32'd4));
        q_addr.push_back(mk(lane, c0 + 2, 32'd253 + idx));
        if (!rst_wait) q_pc.push_back(mk(lane, c0 + 3 + lat, {24'b0, b}));
        rd_cyc[lane]  = c0 + 2 + lat;
        rd_byte[lane] = b;
        busy_lo[lane] = c0 + 1;
        busy_hi[lane] = rst_wait ? c0 + 3 : c0 + 3 + lat;
        tick();
        set_req(lane, 1'b0, 4'b0000, 32'h0);
        if (drop_save) set_req(lane, 1'b1, 4'b0001, 32'hDEAD_0000);
        tick();
        set_req(lane, 1'b0, 4'b0000, 32'h0);
        if (drop_save) exp_lost[lane] = 1'b1;
        exp_cause[lane] = cause_exp(4'b0001 << idx);
        if (rte_busy) set_rte(lane, 1'b1);
        tick();
        set_rte(lane, 1'b0);
        if (rst_wait) begin
            set_rst(lane, 1'b1);
            tick();
            set_rst(lane, 1'b0);
            exp_lost[lane]  = 1'b0;
            exp_cause[lane] = 4'b0000;
        end else begin
            repeat (lat) tick();
            if (drop_load) set_req(lane, 1'b1, 4'b0010, 32'hBEEF_0000);
            tick();
            set_req(lane, 1'b0, 4'b0000, 32'h0);
            if (drop_load) exp_lost[lane] = 1'b1;
        end
    endtask

    initial begin
        for (int l = 0; l < 2; l++) begin
            busy_lo[l] = 1; busy_hi[l] = 0; exp_lost[l] = 1'b0;
            exp_cause[l] = 4'b0000; rd_cyc[l] = -1; rd_byte[l] = 8'h00;
        end
        set_req(0, 1'b0, 4'b0000, 32'h0);
        set_req(1, 1'b0, 4'b0000, 32'h0);
        set_rte(0, 1'b0);
        set_rte(1, 1'b0);
        rst1 = 1'b1;
        rst3 = 1'b1;
        repeat (3) tick();
        rst1 = 1'b0;
        rst3 = 1'b0;
        mon_en = 1'b1;
        check_zero(0);
        check_zero(1);
        tick();

        // Default case, then multi-hot priority (cause 2 -> 0xFF)
        seq(0, 4'b0010, 32'h0000_0104, 8'h5C, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        seq(0, 4'b1100, 32'h0000_0200, 8'h33, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        // Drops in SAVE and LOAD, then a request right after LOAD is serviced
        seq(0, 4'b1000, 32'h0000_0300, 8'h7A, 1, 1'b1, 1'b1, 1'b0, 1'b0);
        seq(0, 4'b0001, 32'h0000_0400, 8'hA5, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Zero cause while idle is ignored
        set_req(0, 1'b1, 4'b0000, 32'h0000_0700);
        tick();
        set_req(0, 1'b0, 4'b0000, 32'h0);
        tick();
        // Cause 3 with rte while busy, then rte while idle
        seq(0, 4'b1000, 32'h0000_0500, 8'h11, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        set_rte(0, 1'b1);
        tick();
        set_rte(0, 1'b0);
        exp_cause[0] = 4'b0000;
        tick();
        // Reset in WAIT aborts without pc_we and clears exc_lost
        seq(0, 4'b0100, 32'h0000_0600, 8'h99, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        check_zero(0);
        repeat (3) tick();
        seq(0, 4'b0001, 32'h0000_0800, 8'h42, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // MEM_LAT=3 lane, including EPC wrap-around
        seq(1, 4'b0001, 32'h0000_1000, 8'hC3, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        seq(1, 4'b0100, 32'h0000_0002, 8'h80, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();

        chk("q_epc_left", 0, q_epc.size(), 32'd0);
        chk("q_addr_left", 0, q_addr.size(), 32'd0);
        chk("q_pc_left", 0, q_pc.size(), 32'd0);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

`default_nettype wire
